// File: rtl/float_discriminant_classifier_if.sv
// float_discriminant_classifier_if: discriminant result stream in, classified FIFO stream out
interface float_discriminant_classifier_if #(parameter int FLEN = 64);
  logic            disc_vld;
  logic [FLEN-1:0] disc;
  logic            disc_negative;
  logic            disc_err;
  logic            out_vld;
  logic            out_ready;
  logic [FLEN-1:0] out_disc;
  logic [1:0]      out_class;
  logic            almost_full;
  modport master (
    output disc_vld, disc, disc_negative, disc_err, out_ready,
    input  out_vld, out_disc, out_class, almost_full
  );
  modport slave (
    input  disc_vld, disc, disc_negative, disc_err, out_ready,
    output out_vld, out_disc, out_class, almost_full
  );
endinterface

// File: rtl/float_discriminant_classifier.sv
// float_discriminant_classifier: root-count classifier with FIFO; per-class stats when FLOAT_DISC_CLASS_STATS_EN is defined
module float_discriminant_classifier #(
  parameter int FLEN      = 64,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 2,
  parameter int CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  float_discriminant_classifier_if.slave  bus,
  output logic                            overflow,
  input  logic                            stat_clear,
  output logic [CNT_W-1:0]                cnt_none,
  output logic [CNT_W-1:0]                cnt_one,
  output logic [CNT_W-1:0]                cnt_two,
  output logic [CNT_W-1:0]                cnt_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [1:0]      cls;
  logic [FLEN-1:0] mem_disc [DEPTH];
  logic [1:0]      mem_cls  [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            full;
  logic            push;
  logic            pop;
  logic            af_nxt;
  always_comb
    cls = bus.disc_err ? 2'd3 : ~|bus.disc[FLEN-2:0] ? 2'd1 : bus.disc_negative ? 2'd0 : 2'd2;
  assign full          = count == CW'(DEPTH);
  assign pop           = bus.out_vld & bus.out_ready;
  assign push          = bus.disc_vld & (~full | pop);
  assign count_nxt     = count + CW'(push) - CW'(pop);
  assign af_nxt        = (DEPTH - int'(count_nxt)) <= AF_THRESH;
  assign bus.out_vld   = count != '0;
  assign bus.out_disc  = bus.out_vld ? mem_disc[rd_ptr] : '0;
  assign bus.out_class = bus.out_vld ? mem_cls[rd_ptr] : 2'd0;
  always_ff @(posedge clk)
    if (rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      overflow        <= 1'b0;
      bus.almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (bus.disc_vld & ~push) overflow <= 1'b1;
      count           <= count_nxt;
      bus.almost_full <= af_nxt;
    end
  always_ff @(posedge clk)
    if (push & ~rst) begin
      mem_disc[wr_ptr] <= bus.disc;
      mem_cls[wr_ptr]  <= cls;
    end
`ifdef FLOAT_DISC_CLASS_STATS_EN
  logic [CNT_W-1:0] cnt [4];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (rst | stat_clear) cnt[i] <= '0;
      else if (bus.disc_vld && cls == 2'(i) && ~&cnt[i]) cnt[i] <= cnt[i] + 1'b1;
  assign cnt_none = cnt[0];
  assign cnt_one  = cnt[1];
  assign cnt_two  = cnt[2];
  assign cnt_err  = cnt[3];
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign cnt_none = '0;
  assign cnt_one  = '0;
  assign cnt_two  = '0;
  assign cnt_err  = '0;
`endif
endmodule
